// File: rtl/bus_master_arb.sv
// Shared RAM bus arbiter: the 8088 owns the bus by default. On-chip masters
// obtain it through a HOLD/HLDA handshake and can then hand it from one to
// the next without returning it to the CPU.
module bus_master_arb #(
  parameter int NREQ      = 2,
  parameter int AW        = 20,
  parameter int DW        = 16,
  parameter int RR        = 0,
  parameter int MAX_GRANT = 0
) (
  input  logic               FCLK,
  input  logic               RESETL,
  input  logic [NREQ-1:0]    REQ,
  output logic [NREQ-1:0]    GNT,
  output logic               HOLD,
  input  logic               HLDA,
  input  logic               ALE,
  input  logic [AW-1:0]      CPU_A,
  input  logic [7:0]         CPU_DOUT,
  input  logic [NREQ*AW-1:0] M_A,
  input  logic [NREQ*DW-1:0] M_DOUT,
  input  logic [NREQ-1:0]    M_WR,
  input  logic [NREQ-1:0]    M_WORD,
  output logic [AW-1:0]      ABus,
  output logic               Write,
  output logic               Word,
  output logic [DW-1:0]      outRamData,
  output logic [3:0]         OWNER
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    ST_CPU,
    ST_HOLDREQ,
    ST_GRANT,
    ST_PREEMPT,
    ST_HANDOFF,
    ST_DROP
  } state_t;

  state_t          state_reg, state_next;
  logic [IW-1:0]   win_reg, win_next;
  logic [IW-1:0]   rr_ptr_reg;
  logic [15:0]     gcnt_reg;
  logic [7:0]      ale_reg;
  logic [IW-1:0]   pick;
  logic            pick_valid;
  logic            grant_load;
  logic [NREQ-1:0] win_mask;
  logic            other_pending;
  logic            cnt_hit;
  int              sel_idx;
  int              sel_base;

  // Per-master views of the packed master buses
  logic [AW-1:0] m_a    [NREQ];
  logic [DW-1:0] m_dout [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign m_a[gi]    = M_A[gi*AW +: AW];
    assign m_dout[gi] = M_DOUT[gi*DW +: DW];
  end

  // Winner search: scan from the highest offset down so the first request at
  // or after the base index is the one left standing.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    sel_idx    = 0;
    sel_base   = (RR != 0) ? int'(rr_ptr_reg) : 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sel_idx = (sel_base + k) % NREQ;
      if (REQ[IW'(sel_idx)]) begin
        pick       = IW'(sel_idx);
        pick_valid = 1'b1;
      end
    end
  end

  // One-hot of the current owner and preemption qualifiers
  always_comb begin
    win_mask          = '0;
    win_mask[win_reg] = 1'b1;
    other_pending     = |(REQ & ~win_mask);
    cnt_hit           = (MAX_GRANT != 0) && (int'(gcnt_reg) == MAX_GRANT - 1);
  end

  // State register
  always_ff @(posedge FCLK or negedge RESETL) begin
    if (!RESETL) state_reg <= ST_CPU;
    else         state_reg <= state_next;
  end

  // Owner, round-robin pointer and grant-length counter
  always_ff @(posedge FCLK or negedge RESETL) begin
    if (!RESETL) begin
      win_reg    <= '0;
      rr_ptr_reg <= '0;
      gcnt_reg   <= '0;
    end else begin
      win_reg <= win_next;
      if (grant_load) begin
        gcnt_reg   <= '0;
        rr_ptr_reg <= (win_next == IW'(NREQ - 1)) ? '0 : win_next + 1'b1;
      end else if (state_reg == ST_GRANT) begin
        gcnt_reg <= gcnt_reg + 16'd1;
      end
    end
  end

  // Capture the multiplexed low address byte while ALE is high
  always_ff @(posedge FCLK or negedge RESETL) begin
    if (!RESETL)  ale_reg <= '0;
    else if (ALE) ale_reg <= CPU_A[7:0];
  end

  // Next-state logic; losing HLDA while holding always returns to the CPU
  always_comb begin
    state_next = state_reg;
    win_next   = win_reg;
    grant_load = 1'b0;
    case (state_reg)
      ST_CPU: begin
        if (|REQ) state_next = ST_HOLDREQ;
      end
      ST_HOLDREQ: begin
        if (HLDA && pick_valid) begin
          state_next = ST_GRANT;
          win_next   = pick;
          grant_load = 1'b1;
        end else if (!(|REQ)) begin
          state_next = ST_DROP;
        end
      end
      ST_GRANT: begin
        if (!HLDA)                          state_next = ST_CPU;
        else if (!REQ[win_reg])             state_next = ST_HANDOFF;
        else if (cnt_hit && other_pending)  state_next = ST_PREEMPT;
      end
      ST_PREEMPT: begin
        if (!HLDA)              state_next = ST_CPU;
        else if (!REQ[win_reg]) state_next = ST_HANDOFF;
      end
      ST_HANDOFF: begin
        if (!HLDA) begin
          state_next = ST_CPU;
        end else if (pick_valid) begin
          state_next = ST_GRANT;
          win_next   = pick;
          grant_load = 1'b1;
        end else begin
          state_next = ST_DROP;
        end
      end
      ST_DROP: begin
        if (!HLDA) state_next = ST_CPU;
      end
      default: state_next = ST_CPU;
    endcase
  end

  // Output decode: strobes only pass through while a grant is active
  always_comb begin
    GNT        = '0;
    HOLD       = 1'b0;
    OWNER      = 4'd0;
    Write      = 1'b0;
    Word       = 1'b0;
    ABus       = m_a[win_reg];
    outRamData = m_dout[win_reg];
    case (state_reg)
      ST_CPU: begin
        ABus       = {CPU_A[AW-1:8], ale_reg};
        outRamData = DW'(CPU_DOUT);
      end
      ST_GRANT: begin
        GNT   = win_mask;
        HOLD  = 1'b1;
        OWNER = 4'(win_reg) + 4'd1;
        Write = M_WR[win_reg];
        Word  = M_WORD[win_reg];
      end
      ST_HOLDREQ, ST_PREEMPT, ST_HANDOFF: begin
        HOLD = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_master_arb.sv
// Bench for bus_master_arb: three instances cover fixed priority (default
// parameters), round-robin with three masters, and grant-length preemption.
module tb_bus_master_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        ale;
  logic [19:0] cpu_a;
  logic [7:0]  cpu_dout;

  // u0: NREQ=2, fixed priority, unlimited grant
  logic [1:0]  req0, gnt0, m_wr0, m_word0;
  logic        hlda0, hold0, write0, word0;
  logic [39:0] m_a0;
  logic [31:0] m_dout0;
  logic [19:0] abus0;
  logic [15:0] rdata0;
  logic [3:0]  owner0;

  // u1: NREQ=3, round-robin
  logic [2:0]  req1, gnt1, m_wr1, m_word1;
  logic        hlda1, hold1, write1, word1;
  logic [59:0] m_a1;
  logic [47:0] m_dout1;
  logic [19:0] abus1;
  logic [15:0] rdata1;
  logic [3:0]  owner1;

  // u2: NREQ=2, fixed priority, MAX_GRANT=8
  logic [1:0]  req2, gnt2, m_wr2, m_word2;
  logic        hlda2, hold2, write2, word2;
  logic [39:0] m_a2;
  logic [31:0] m_dout2;
  logic [19:0] abus2;
  logic [15:0] rdata2;
  logic [3:0]  owner2;

  bus_master_arb u0 (
    .FCLK(clk), .RESETL(rst_n), .REQ(req0), .GNT(gnt0), .HOLD(hold0), .HLDA(hlda0),
    .ALE(ale), .CPU_A(cpu_a), .CPU_DOUT(cpu_dout), .M_A(m_a0), .M_DOUT(m_dout0),
    .M_WR(m_wr0), .M_WORD(m_word0), .ABus(abus0), .Write(write0), .Word(word0),
    .outRamData(rdata0), .OWNER(owner0)
  );

  bus_master_arb #(.NREQ(3), .RR(1)) u1 (
    .FCLK(clk), .RESETL(rst_n), .REQ(req1), .GNT(gnt1), .HOLD(hold1), .HLDA(hlda1),
    .ALE(ale), .CPU_A(cpu_a), .CPU_DOUT(cpu_dout), .M_A(m_a1), .M_DOUT(m_dout1),
    .M_WR(m_wr1), .M_WORD(m_word1), .ABus(abus1), .Write(write1), .Word(word1),
    .outRamData(rdata1), .OWNER(owner1)
  );

  bus_master_arb #(.MAX_GRANT(8)) u2 (
    .FCLK(clk), .RESETL(rst_n), .REQ(req2), .GNT(gnt2), .HOLD(hold2), .HLDA(hlda2),
    .ALE(ale), .CPU_A(cpu_a), .CPU_DOUT(cpu_dout), .M_A(m_a2), .M_DOUT(m_dout2),
    .M_WR(m_wr2), .M_WORD(m_word2), .ABus(abus2), .Write(write2), .Word(word2),
    .outRamData(rdata2), .OWNER(owner2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  req;
    logic        hlda;
    logic        ale;
    logic [19:0] cpu_a;
    logic [1:0]  gnt;
    logic        hold;
    logic [3:0]  owner;
    logic        chk_abus;
    logic [19:0] abus;
    logic        write;
    logic        word;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs[NV];

  initial begin
    int n;
    int w;
    int order[4];

    // Applied inputs, then expected outputs after the following rising edge
    vecs[0]  = '{2'b00, 1'b0, 1'b1, 20'h12345, 2'b00, 1'b0, 4'd0, 1'b1, 20'h12345, 1'b0, 1'b0};
    vecs[1]  = '{2'b00, 1'b0, 1'b0, 20'h123FF, 2'b00, 1'b0, 4'd0, 1'b1, 20'h12345, 1'b0, 1'b0};
    vecs[2]  = '{2'b01, 1'b0, 1'b0, 20'h123FF, 2'b00, 1'b1, 4'd0, 1'b0, 20'h00000, 1'b0, 1'b0};
    vecs[3]  = '{2'b01, 1'b0, 1'b0, 20'h123FF, 2'b00, 1'b1, 4'd0, 1'b0, 20'h00000, 1'b0, 1'b0};
    vecs[4]  = '{2'b01, 1'b0, 1'b0, 20'h123FF, 2'b00, 1'b1, 4'd0, 1'b0, 20'h00000, 1'b0, 1'b0};
    vecs[5]  = '{2'b01, 1'b1, 1'b0, 20'h123FF, 2'b01, 1'b1, 4'd1, 1'b1, 20'hAAAAA, 1'b1, 1'b0};
    vecs[6]  = '{2'b01, 1'b1, 1'b0, 20'h123FF, 2'b01, 1'b1, 4'd1, 1'b1, 20'hAAAAA, 1'b1, 1'b0};
    vecs[7]  = '{2'b00, 1'b1, 1'b0, 20'h123FF, 2'b00, 1'b1, 4'd0, 1'b0, 20'h00000, 1'b0, 1'b0};
    vecs[8]  = '{2'b00, 1'b1, 1'b0, 20'h123FF, 2'b00, 1'b0, 4'd0, 1'b0, 20'h00000, 1'b0, 1'b0};
    vecs[9]  = '{2'b00, 1'b1, 1'b0, 20'h123FF, 2'b00, 1'b0, 4'd0, 1'b0, 20'h00000, 1'b0, 1'b0};
    vecs[10] = '{2'b00, 1'b0, 1'b0, 20'h123FF, 2'b00, 1'b0, 4'd0, 1'b1, 20'h12345, 1'b0, 1'b0};
    vecs[11] = '{2'b11, 1'b0, 1'b0, 20'h123FF, 2'b00, 1'b1, 4'd0, 1'b0, 20'h00000, 1'b0, 1'b0};
    vecs[12] = '{2'b11, 1'b1, 1'b0, 20'h123FF, 2'b01, 1'b1, 4'd1, 1'b1, 20'hAAAAA, 1'b1, 1'b0};
    vecs[13] = '{2'b10, 1'b1, 1'b0, 20'h123FF, 2'b00, 1'b1, 4'd0, 1'b0, 20'h00000, 1'b0, 1'b0};
    vecs[14] = '{2'b10, 1'b1, 1'b0, 20'h123FF, 2'b10, 1'b1, 4'd2, 1'b1, 20'hBBBBB, 1'b1, 1'b1};
    vecs[15] = '{2'b10, 1'b1, 1'b0, 20'h123FF, 2'b10, 1'b1, 4'd2, 1'b1, 20'hBBBBB, 1'b1, 1'b1};
    vecs[16] = '{2'b00, 1'b1, 1'b0, 20'h123FF, 2'b00, 1'b1, 4'd0, 1'b0, 20'h00000, 1'b0, 1'b0};
    vecs[17] = '{2'b00, 1'b1, 1'b0, 20'h123FF, 2'b00, 1'b0, 4'd0, 1'b0, 20'h00000, 1'b0, 1'b0};
    vecs[18] = '{2'b00, 1'b0, 1'b0, 20'h123FF, 2'b00, 1'b0, 4'd0, 1'b1, 20'h12345, 1'b0, 1'b0};
    vecs[19] = '{2'b01, 1'b0, 1'b0, 20'h123FF, 2'b00, 1'b1, 4'd0, 1'b0, 20'h00000, 1'b0, 1'b0};
    vecs[20] = '{2'b01, 1'b1, 1'b0, 20'h123FF, 2'b01, 1'b1, 4'd1, 1'b1, 20'hAAAAA, 1'b1, 1'b0};
    vecs[21] = '{2'b01, 1'b0, 1'b0, 20'h123FF, 2'b00, 1'b0, 4'd0, 1'b1, 20'h12345, 1'b0, 1'b0};
    vecs[22] = '{2'b01, 1'b0, 1'b0, 20'h123FF, 2'b00, 1'b1, 4'd0, 1'b0, 20'h00000, 1'b0, 1'b0};
    vecs[23] = '{2'b00, 1'b0, 1'b0, 20'h123FF, 2'b00, 1'b0, 4'd0, 1'b0, 20'h00000, 1'b0, 1'b0};
    vecs[24] = '{2'b00, 1'b0, 1'b0, 20'h123FF, 2'b00, 1'b0, 4'd0, 1'b1, 20'h12345, 1'b0, 1'b0};

    rst_n    = 1'b0;
    ale      = 1'b0;
    cpu_a    = 20'h0;
    cpu_dout = 8'h5A;
    req0 = '0; hlda0 = 1'b0; m_a0 = {20'hBBBBB, 20'hAAAAA}; m_dout0 = {16'hD1D1, 16'hD0D0};
    m_wr0 = 2'b11; m_word0 = 2'b10;
    req1 = '0; hlda1 = 1'b0; m_a1 = {20'h22222, 20'h11111, 20'h00000}; m_dout1 = '0;
    m_wr1 = 3'b000; m_word1 = 3'b000;
    req2 = '0; hlda2 = 1'b0; m_a2 = {20'hBBBBB, 20'hAAAAA}; m_dout2 = {16'hE1E1, 16'hE0E0};
    m_wr2 = 2'b11; m_word2 = 2'b00;

    // Reset state
    step();
    check("rst_gnt",   32'(gnt0),   32'h0);
    check("rst_hold",  32'(hold0),  32'h0);
    check("rst_owner", 32'(owner0), 32'h0);
    check("rst_write", 32'(write0), 32'h0);
    check("rst_word",  32'(word0),  32'h0);
    check("rst_abus",  32'(abus0),  32'h0);
    check("rst_rdata", 32'(rdata0), 32'h005A);
    check("rst_gnt1",  32'(gnt1),   32'h0);
    check("rst_hold2", 32'(hold2),  32'h0);
    rst_n = 1'b1;

    // Fixed-priority table: ALE latch, basic grant, hand-over, protocol error
    for (int i = 0; i < NV; i++) begin
      req0  = vecs[i].req;
      hlda0 = vecs[i].hlda;
      ale   = vecs[i].ale;
      cpu_a = vecs[i].cpu_a;
      step();
      $display("vec %0d: req=%b hlda=%b -> gnt=%b hold=%b owner=%0d abus=%h write=%b word=%b",
               i, req0, hlda0, gnt0, hold0, owner0, abus0, write0, word0);
      check($sformatf("v%0d_gnt", i),   32'(gnt0),   32'(vecs[i].gnt));
      check($sformatf("v%0d_hold", i),  32'(hold0),  32'(vecs[i].hold));
      check($sformatf("v%0d_owner", i), 32'(owner0), 32'(vecs[i].owner));
      check($sformatf("v%0d_write", i), 32'(write0), 32'(vecs[i].write));
      check($sformatf("v%0d_word", i),  32'(word0),  32'(vecs[i].word));
      if (vecs[i].chk_abus)
        check($sformatf("v%0d_abus", i), 32'(abus0), 32'(vecs[i].abus));
    end

    // Round-robin: all three masters keep requesting, each releases after 4 cycles
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 0;
    req1  = 3'b111;
    hlda1 = 1'b1;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      while (gnt1 == 3'b000 && n < 20) begin
        step();
        n++;
      end
      w = order[g];
      $display("rr grant %0d: gnt=%b owner=%0d abus=%h", g, gnt1, owner1, abus1);
      check($sformatf("rr%0d_gnt", g),   32'(gnt1),   32'(3'b001 << w));
      check($sformatf("rr%0d_owner", g), 32'(owner1), 32'(w + 1));
      repeat (3) step();
      check($sformatf("rr%0d_held", g),  32'(gnt1),   32'(3'b001 << w));
      req1[w] = 1'b0;
      step();
      check($sformatf("rr%0d_turn_gnt", g),  32'(gnt1),  32'h0);
      check($sformatf("rr%0d_turn_hold", g), 32'(hold1), 32'h1);
      req1[w] = 1'b1;
    end
    req1  = 3'b000;
    hlda1 = 1'b0;

    // Preemption: master 0 holds on, master 1 asks at cycle 2
    req2  = 2'b01;
    hlda2 = 1'b1;
    step();
    step();
    check("pre_first_gnt", 32'(gnt2), 32'h1);
    n = 1;
    step();
    check("pre_second_gnt", 32'(gnt2), 32'h1);
    n = 2;
    req2 = 2'b11;
    while (n < 20) begin
      step();
      if (gnt2 == 2'b01) n++;
      else break;
    end
    $display("preempt: master 0 held the grant for %0d cycles", n);
    check("pre_len",   32'(n),      32'd8);
    check("pre_gnt",   32'(gnt2),   32'h0);
    check("pre_hold",  32'(hold2),  32'h1);
    check("pre_write", 32'(write2), 32'h0);
    repeat (2) step();
    check("pre_wait_gnt",   32'(gnt2),   32'h0);
    check("pre_wait_write", 32'(write2), 32'h0);
    req2 = 2'b10;
    step();
    check("pre_turn_gnt",  32'(gnt2),  32'h0);
    check("pre_turn_hold", 32'(hold2), 32'h1);
    step();
    $display("preempt hand-over: gnt=%b owner=%0d write=%b rdata=%h", gnt2, owner2, write2, rdata2);
    check("pre_new_gnt",   32'(gnt2),   32'h2);
    check("pre_new_owner", 32'(owner2), 32'd2);
    check("pre_new_rdata", 32'(rdata2), 32'hE1E1);
    check("rst_pre_write", 32'(write2), 32'h1);

    // Asynchronous reset in the middle of a write grant
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset: gnt=%b hold=%b write=%b", gnt2, hold2, write2);
    check("arst_gnt",   32'(gnt2),   32'h0);
    check("arst_hold",  32'(hold2),  32'h0);
    check("arst_write", 32'(write2), 32'h0);
    hlda2 = 1'b0;
    step();
    rst_n = 1'b1;
    check("arst_rel_hold", 32'(hold2), 32'h0);
    step();
    $display("after reset release: hold=%b", hold2);
    check("arst_rehold", 32'(hold2), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
